// File: rtl/ad80305_tx_if_lvcmos_31p25.sv
// AD80305 TX LVCMOS interface: FIFO-buffered 12-bit I/Q, DDR-style bus in the 125 MHz domain.
// Optional fs/4 test tone is built only when TX_TONE_GEN_EN is defined.
module ad80305_tx_if_lvcmos_31p25 #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PREFILL = 2
) (
    input  logic                     i_fpga_clk_125p,
    input  logic                     i_fpga_rst_125p,
    input  logic                     i_tx_en,
    input  logic                     i_iqdata_fp,
    input  logic [11:0]              i_idata,
    input  logic [11:0]              i_qdata,
    input  logic                     i_test_en,
    output logic                     o_fb_clk,
    output logic                     o_tx_frame,
    output logic [11:0]              o_tx_data,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_underflow,
    output logic                     o_overflow
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthLvl   = DEPTH[PtrW:0];
    localparam logic [PtrW:0] PrefillLvl = PREFILL[PtrW:0];

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e          state_q, state_d;
    logic [1:0]      phase_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   level_q;
    logic [23:0]     mem [DEPTH];
    logic [11:0]     s_i_q, s_i_d, s_q_q, s_q_d;
    logic            push, pop, ovf_d, unf_d, fetch;
    logic            tone_sel;
    logic [11:0]     tone_i, tone_q;

    assign fetch = (phase_q == 2'd3);

`ifdef TX_TONE_GEN_EN
    logic       test_en_q, fetch_tone;
    logic [1:0] tone_idx_q, tone_base;

    assign tone_sel   = i_test_en && (state_q == StFill || state_q == StRun);
    assign fetch_tone = fetch && i_tx_en && tone_sel;
    // Sequence restarts at (+2047,0) on a rising i_test_en.
    assign tone_base  = (i_test_en && !test_en_q) ? 2'd0 : tone_idx_q;

    always_comb begin
        tone_i = 12'd0;
        tone_q = 12'd0;
        case (tone_base)
            2'd0: tone_i = 12'h7ff;
            2'd1: tone_q = 12'h7ff;
            2'd2: tone_i = 12'h801;
            default: tone_q = 12'h801;
        endcase
    end

    always_ff @(posedge i_fpga_clk_125p) begin
        if (i_fpga_rst_125p) begin
            test_en_q  <= 1'b0;
            tone_idx_q <= 2'd0;
        end else begin
            test_en_q  <= i_test_en;
            tone_idx_q <= fetch_tone ? tone_base + 2'd1 : tone_base;
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = i_test_en;
    assign tone_sel = 1'b0;
    assign tone_i   = 12'd0;
    assign tone_q   = 12'd0;
`endif

    always_comb begin
        state_d = state_q;
        s_i_d   = s_i_q;
        s_q_d   = s_q_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (!i_tx_en) begin
            state_d = StIdle;
            s_i_d   = 12'd0;
            s_q_d   = 12'd0;
        end else begin
            if (fetch) begin
                s_i_d = 12'd0;
                s_q_d = 12'd0;
                if (tone_sel) begin
                    s_i_d = tone_i;
                    s_q_d = tone_q;
                end else begin
                    case (state_q)
                        StIdle: state_d = StFill;
                        StFill: begin
                            if (level_q >= PrefillLvl) begin
                                pop     = 1'b1;
                                state_d = StRun;
                            end
                        end
                        StRun: begin
                            if (level_q != '0) begin
                                pop = 1'b1;
                            end else begin
                                unf_d   = 1'b1;
                                state_d = StFill;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                    if (pop) begin
                        s_i_d = mem[rd_ptr_q][11:0];
                        s_q_d = mem[rd_ptr_q][23:12];
                    end
                end
            end else if (state_q == StIdle) begin
                state_d = StFill;
            end
            // Full only blocks the push when nothing leaves this cycle.
            if (i_iqdata_fp) begin
                if (level_q == DepthLvl && !pop) ovf_d = 1'b1;
                else                             push  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_fpga_clk_125p) begin
        if (push) mem[wr_ptr_q] <= {i_qdata, i_idata};
    end

    always_ff @(posedge i_fpga_clk_125p) begin
        if (i_fpga_rst_125p) begin
            state_q  <= StIdle;
            phase_q  <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            s_i_q    <= 12'd0;
            s_q_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_q + 2'd1;
            s_i_q   <= s_i_d;
            s_q_q   <= s_q_d;
            if (!i_tx_en) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    // Clock edges land one cycle into each data word.
    always_ff @(posedge i_fpga_clk_125p) begin
        if (i_fpga_rst_125p) begin
            o_fb_clk    <= 1'b0;
            o_tx_frame  <= 1'b0;
            o_tx_data   <= 12'd0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            case (phase_q)
                2'd0: begin
                    o_tx_data  <= s_i_q;
                    o_tx_frame <= 1'b1;
                end
                2'd1: o_fb_clk <= 1'b1;
                2'd2: begin
                    o_tx_data  <= s_q_q;
                    o_tx_frame <= 1'b0;
                end
                default: o_fb_clk <= 1'b0;
            endcase
            if (!i_tx_en) o_tx_data <= 12'd0;
            o_underflow <= unf_d;
            o_overflow  <= ovf_d;
        end
    end

    assign o_fifo_level = level_q;

endmodule
